// File: rtl/csr_write_seq_pkg.sv
// Shared types and constants for the machine-mode CSR write sequencer.
// State enum, op encodings, mstatus fields and CSR addresses.
package pipes;

  localparam int XLEN = 64;

  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  typedef enum logic [2:0] {
    IDLE,
    W_INST,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS_T,
    W_MSTATUS_R,
    REDIRECT
  } csr_seq_state_t;

  typedef struct packed {
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
  } csr_t;

  function automatic logic [XLEN-1:0] mstatus_trap(
    input logic [XLEN-1:0] s
  );
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_mret(
    input logic [XLEN-1:0] s
  );
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/csr_write_seq_trap_target.sv
// Trap PC from mtvec and mcause: direct mode, or vectored
// for interrupts when mtvec[1:0]==01. Wraps modulo 2^WIDTH.
module csr_trap_target #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] cause,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] offs;
  logic             vec;

  assign base = {mtvec[WIDTH-1:2], 2'b00};
  assign offs = {cause[WIDTH-3:0], 2'b00};
  assign vec  = (mtvec[1:0] == 2'b01) & cause[WIDTH-1];

  // Interrupt vectoring adds 4*cause to the aligned base
  always_comb begin
    target = base;
    if (vec) target = base + offs;
  end

endmodule

// File: rtl/csr_write_seq.sv
// Write sequencer for the M-mode CSR file: CSR ops, trap entry, MRET.
// Optional mtval write in trap entry: define CSR_SEQ_MTVAL_EN.
module csr_write_seq
  import pipes::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  csr_t             csr_i,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [1:0]       inst_op,
  input  logic [11:0]      inst_addr,
  input  logic [WIDTH-1:0] inst_src,
  output logic [11:0]      csr_rd_addr,
  input  logic [WIDTH-1:0] csr_rd_data,
  output logic             inst_done,
  output logic [WIDTH-1:0] inst_old,
  input  logic             trap_valid,
  output logic             trap_ready,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic [WIDTH-1:0] trap_cause,
  input  logic [WIDTH-1:0] trap_tval,
  input  logic             mret_valid,
  output logic             mret_ready,
  output logic             wen,
  output logic [11:0]      wa,
  output logic [WIDTH-1:0] wd,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy
);

  csr_seq_state_t   state;
  logic [WIDTH-1:0] cause_q;
  logic [WIDTH-1:0] mtvec_q;
  logic [WIDTH-1:0] mepc_q;
  logic [WIDTH-1:0] trap_tgt;
  logic [WIDTH-1:0] inst_wd;
  logic             inst_wen;
  logic             idle;

`ifdef CSR_SEQ_MTVAL_EN
  logic [WIDTH-1:0] tval_q;
`else
  logic             unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  assign idle        = (state == IDLE);
  assign trap_ready  = reset & idle;
  assign mret_ready  = reset & idle & ~trap_valid;
  assign inst_ready  = reset & idle & ~trap_valid & ~mret_valid;
  assign csr_rd_addr = inst_addr;

  csr_trap_target #(.WIDTH(WIDTH)) u_tgt (
    .mtvec  (mtvec_q),
    .cause  (cause_q),
    .target (trap_tgt)
  );

  // Write data for an incoming CSR op; set/clear by zero skips the write
  always_comb begin
    inst_wd  = inst_src;
    inst_wen = 1'b1;
    unique case (inst_op)
      CSR_OP_RW: inst_wd = inst_src;
      CSR_OP_RS: inst_wd = csr_rd_data | inst_src;
      CSR_OP_RC: inst_wd = csr_rd_data & ~inst_src;
      default:   inst_wen = 1'b0;
    endcase
    if (inst_op != CSR_OP_RW && inst_src == '0) inst_wen = 1'b0;
  end

  // Sequencer FSM; outputs are registered alongside the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cause_q        <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
`ifdef CSR_SEQ_MTVAL_EN
      tval_q         <= '0;
`endif
      wen            <= 1'b0;
      wa             <= '0;
      wd             <= '0;
      inst_done      <= 1'b0;
      inst_old       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      wen            <= 1'b0;
      wa             <= '0;
      wd             <= '0;
      inst_done      <= 1'b0;
      inst_old       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b1;
      unique case (state)
        IDLE: begin
          busy    <= 1'b0;
          mtvec_q <= csr_i.mtvec[WIDTH-1:0];
          mepc_q  <= csr_i.mepc[WIDTH-1:0];
          if (trap_valid) begin
            state   <= W_MEPC;
            cause_q <= trap_cause;
`ifdef CSR_SEQ_MTVAL_EN
            tval_q  <= trap_tval;
`endif
            wen     <= 1'b1;
            wa      <= CSR_MEPC;
            wd      <= trap_pc;
            busy    <= 1'b1;
          end else if (mret_valid) begin
            state <= W_MSTATUS_R;
            wen   <= 1'b1;
            wa    <= CSR_MSTATUS;
            wd    <= WIDTH'(mstatus_mret(csr_i.mstatus));
            busy  <= 1'b1;
          end else if (inst_valid) begin
            state     <= W_INST;
            wen       <= inst_wen;
            wa        <= inst_wen ? inst_addr : 12'h000;
            wd        <= inst_wen ? inst_wd : '0;
            inst_done <= 1'b1;
            inst_old  <= csr_rd_data;
            busy      <= 1'b1;
          end
        end
        W_INST: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        W_MEPC: begin
          state <= W_MCAUSE;
          wen   <= 1'b1;
          wa    <= CSR_MCAUSE;
          wd    <= cause_q;
        end
        W_MCAUSE: begin
`ifdef CSR_SEQ_MTVAL_EN
          state <= W_MTVAL;
          wen   <= 1'b1;
          wa    <= CSR_MTVAL;
          wd    <= tval_q;
`else
          state <= W_MSTATUS_T;
          wen   <= 1'b1;
          wa    <= CSR_MSTATUS;
          wd    <= WIDTH'(mstatus_trap(csr_i.mstatus));
`endif
        end
        W_MTVAL: begin
          state <= W_MSTATUS_T;
          wen   <= 1'b1;
          wa    <= CSR_MSTATUS;
          wd    <= WIDTH'(mstatus_trap(csr_i.mstatus));
        end
        W_MSTATUS_T: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_tgt;
        end
        W_MSTATUS_R: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_q;
        end
        REDIRECT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_write_seq.sv
// Self-checking bench for csr_write_seq: vector table for CSR ops,
// hand sequences for trap, vectored trap, MRET and mid-sequence reset.
module tb_csr_write_seq;
  import pipes::*;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  csr_t          csr_i;
  logic          inst_valid = 1'b0;
  logic          inst_ready;
  logic [1:0]    inst_op = 2'b00;
  logic [11:0]   inst_addr = 12'h000;
  logic [W-1:0]  inst_src = '0;
  logic [11:0]   csr_rd_addr;
  logic [W-1:0]  csr_rd_data = '0;
  logic          inst_done;
  logic [W-1:0]  inst_old;
  logic          trap_valid = 1'b0;
  logic          trap_ready;
  logic [W-1:0]  trap_pc = '0;
  logic [W-1:0]  trap_cause = '0;
  logic [W-1:0]  trap_tval = '0;
  logic          mret_valid = 1'b0;
  logic          mret_ready;
  logic          wen;
  logic [11:0]   wa;
  logic [W-1:0]  wd;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_write_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .csr_i          (csr_i),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_op        (inst_op),
    .inst_addr      (inst_addr),
    .inst_src       (inst_src),
    .csr_rd_addr    (csr_rd_addr),
    .csr_rd_data    (csr_rd_data),
    .inst_done      (inst_done),
    .inst_old       (inst_old),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .mret_valid     (mret_valid),
    .mret_ready     (mret_ready),
    .wen            (wen),
    .wa             (wa),
    .wd             (wd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  typedef struct {
    logic [1:0]   op;
    logic [11:0]  addr;
    logic [W-1:0] src;
    logic [W-1:0] old;
    logic         exp_wen;
    logic [W-1:0] exp_wd;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string nm, input logic [11:0] a,
                        input logic [W-1:0] d);
    chk({nm, "_wen"}, W'(wen), W'(1'b1));
    chk({nm, "_wa"}, W'(wa), W'(a));
    chk({nm, "_wd"}, wd, d);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_wen"}, W'(wen), '0);
    chk({nm, "_wa"}, W'(wa), '0);
    chk({nm, "_wd"}, wd, '0);
    chk({nm, "_rv"}, W'(redirect_valid), '0);
    chk({nm, "_rpc"}, redirect_pc, '0);
    chk({nm, "_done"}, W'(inst_done), '0);
    chk({nm, "_old"}, inst_old, '0);
    chk({nm, "_busy"}, W'(busy), '0);
  endtask

  // Run one trap; returns cycles from accept to redirect and its pc
  task automatic run_trap(input logic [W-1:0] pc,
                          input logic [W-1:0] cause,
                          input logic [W-1:0] tval,
                          output int lat, output logic [W-1:0] rpc);
    trap_pc    = pc;
    trap_cause = cause;
    trap_tval  = tval;
    trap_valid = 1'b1;
    chk("trap_ready", W'(trap_ready), W'(1'b1));
    tick();
    trap_valid = 1'b0;
    lat = 0;
    rpc = '0;
    for (int i = 1; i <= 8; i++) begin
      if (redirect_valid) begin
        lat = i;
        rpc = redirect_pc;
        break;
      end
      tick();
    end
  endtask

  logic [W-1:0] rpc;
  int           lat;
  int           exp_lat;

  initial begin
    csr_i = '0;
`ifdef CSR_SEQ_MTVAL_EN
    exp_lat = 5;
`else
    exp_lat = 4;
`endif

    vt[0] = '{CSR_OP_RW, CSR_MSCRATCH, 64'h1234, 64'hAA, 1'b1, 64'h1234};
    vt[1] = '{CSR_OP_RS, CSR_MSTATUS, 64'h0, 64'h88, 1'b0, 64'h0};
    vt[2] = '{CSR_OP_RS, CSR_MSCRATCH, 64'hF0, 64'h0F, 1'b1, 64'hFF};
    vt[3] = '{CSR_OP_RC, CSR_MSCRATCH, 64'h0F, 64'hFF, 1'b1, 64'hF0};
    vt[4] = '{CSR_OP_RC, CSR_MEPC, 64'h0, 64'h55, 1'b0, 64'h0};
    vt[5] = '{CSR_OP_RW, CSR_MSCRATCH, 64'h0, 64'h77, 1'b1, 64'h0};

    tick();
    tick();
    chk_quiet("rst");
    chk("rst_trap_ready", W'(trap_ready), '0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_inst_ready", W'(inst_ready), W'(1'b1));
    chk("rel_busy", W'(busy), '0);

    for (int i = 0; i < 6; i++) begin
      inst_op     = vt[i].op;
      inst_addr   = vt[i].addr;
      inst_src    = vt[i].src;
      csr_rd_data = vt[i].old;
      inst_valid  = 1'b1;
      chk($sformatf("v%0d_rdaddr", i), W'(csr_rd_addr), W'(vt[i].addr));
      chk($sformatf("v%0d_ready", i), W'(inst_ready), W'(1'b1));
      tick();
      inst_valid  = 1'b0;
      csr_rd_data = '0;
      chk($sformatf("v%0d_done", i), W'(inst_done), W'(1'b1));
      chk($sformatf("v%0d_old", i), inst_old, vt[i].old);
      chk($sformatf("v%0d_wen", i), W'(wen), W'(vt[i].exp_wen));
      chk($sformatf("v%0d_wa", i), W'(wa),
          vt[i].exp_wen ? W'(vt[i].addr) : '0);
      chk($sformatf("v%0d_wd", i), wd, vt[i].exp_wd);
      chk($sformatf("v%0d_busy", i), W'(busy), W'(1'b1));
      chk($sformatf("v%0d_rdy_busy", i), W'(inst_ready), '0);
      tick();
      chk($sformatf("v%0d_done_clr", i), W'(inst_done), '0);
      chk($sformatf("v%0d_idle", i), W'(busy), '0);
    end

    csr_i.mtvec   = 64'h8000_0100;
    csr_i.mstatus = 64'h8;
    trap_pc    = 64'h8000_0010;
    trap_cause = 64'h2;
    trap_tval  = 64'hDEAD;
    trap_valid = 1'b1;
    tick();
    trap_valid = 1'b0;
    chk_wr("t_mepc", CSR_MEPC, 64'h8000_0010);
    chk("t_rv0", W'(redirect_valid), '0);
    tick();
    chk_wr("t_mcause", CSR_MCAUSE, 64'h2);
`ifdef CSR_SEQ_MTVAL_EN
    tick();
    chk_wr("t_mtval", CSR_MTVAL, 64'hDEAD);
`endif
    tick();
    chk_wr("t_mstatus", CSR_MSTATUS, 64'h1880);
    tick();
    chk("t_rv", W'(redirect_valid), W'(1'b1));
    chk("t_rpc", redirect_pc, 64'h8000_0100);
    chk("t_rwen", W'(wen), '0);
    tick();
    chk_quiet("t_end");
    chk("t_ready", W'(trap_ready), W'(1'b1));

    csr_i.mtvec = 64'h8000_0101;
    run_trap(64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0, lat, rpc);
    chk("vt_lat", W'(lat), W'(exp_lat));
    chk("vt_rpc", rpc, 64'h8000_011C);
    tick();

    run_trap(64'h8000_0020, 64'h3, 64'h0, lat, rpc);
    chk("vx_lat", W'(lat), W'(exp_lat));
    chk("vx_rpc", rpc, 64'h8000_0100);
    tick();

    csr_i.mstatus = 64'h1880;
    csr_i.mepc    = 64'h8000_0040;
    mret_valid = 1'b1;
    chk("m_ready", W'(mret_ready), W'(1'b1));
    tick();
    mret_valid = 1'b0;
    chk_wr("m_mstatus", CSR_MSTATUS, 64'h88);
    tick();
    chk("m_rv", W'(redirect_valid), W'(1'b1));
    chk("m_rpc", redirect_pc, 64'h8000_0040);
    chk("m_rwen", W'(wen), '0);
    tick();
    chk_quiet("m_end");

    csr_i.mtvec   = 64'h8000_0100;
    csr_i.mstatus = 64'h8;
    trap_pc     = 64'h100;
    trap_cause  = 64'h5;
    trap_valid  = 1'b1;
    mret_valid  = 1'b1;
    inst_valid  = 1'b1;
    inst_op     = CSR_OP_RW;
    inst_addr   = CSR_MSCRATCH;
    inst_src    = 64'h5;
    csr_rd_data = 64'h1;
    #1;
    chk("p_trap_ready", W'(trap_ready), W'(1'b1));
    chk("p_mret_ready", W'(mret_ready), '0);
    chk("p_inst_ready", W'(inst_ready), '0);
    mret_valid = 1'b0;
    #1;
    chk("p_inst_ready2", W'(inst_ready), '0);
    tick();
    trap_valid = 1'b0;
    chk_wr("p_mepc", CSR_MEPC, 64'h100);
    chk("p_inst_busy", W'(inst_ready), '0);
    tick();
    reset = 1'b0;
    #1;
    chk_quiet("p_rst");
    chk("p_rst_ready", W'(inst_ready), '0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("p_rel_ready", W'(inst_ready), W'(1'b1));
    tick();
    inst_valid = 1'b0;
    chk("p_inst_done", W'(inst_done), W'(1'b1));
    chk("p_inst_old", inst_old, 64'h1);
    chk_wr("p_inst", CSR_MSCRATCH, 64'h5);
    tick();
    chk("p_end_busy", W'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
